// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Owns the program counter and the instruction-memory fetch handshake.
//   Fetches one instruction word, holds it stable for the decoder until the
//   datapath retires it, then computes the next PC and fetches again.
//
// Ports
//   clk, rstn            clock (rising edge), async active-low reset
//   imem_req/addr        fetch request and address (addr is always pc)
//   imem_rdy/rdata       imem data-valid strobe and instruction word
//   instr/instr_valid    held instruction word to the decoder
//   pc, pc_plus4         address of held instruction, pc+4 (combinational)
//   retire, stall        datapath handshake; stall blocks retire
//   npc_op               000 plus4, 001 branch, 010 jal, 100 jalr
//   branch_taken, imm,   next-PC operands
//   alu_result
//   misalign, npc_err,   sticky error flags, cleared only by reset
//   fetch_err
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        branch_taken,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    output logic        misalign,
    output logic        npc_err,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    localparam logic [31:0] TIMEOUT = 32'(IMEM_TIMEOUT);

    state_t      state;
    logic [31:0] tcnt;
    logic [31:0] target;
    logic        illegal_op;

    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;

    // Raw next-PC target before alignment fix-up.
    always_comb begin
        target     = pc_plus4;
        illegal_op = 1'b0;
        case (npc_op)
            3'b000: target = pc_plus4;
            3'b001: target = branch_taken ? (pc + imm) : pc_plus4;
            3'b010: target = pc + imm;
            3'b100: target = alu_result & ~32'h1;
            default: begin
                target     = pc_plus4;
                illegal_op = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            misalign    <= 1'b0;
            npc_err     <= 1'b0;
            fetch_err   <= 1'b0;
            tcnt        <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (!stall) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                FETCH: begin
                    // rdy is honoured even under stall so an in-flight
                    // handshake is never abandoned.
                    if (imem_rdy) begin
                        instr       <= imem_rdata;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        tcnt        <= 32'h0;
                        state       <= HOLD;
                    end else if (TIMEOUT != 32'h0) begin
                        // Flag and restart the wait; the request stays up,
                        // which re-issues it at the same pc.
                        if (tcnt == TIMEOUT - 32'h1) begin
                            fetch_err <= 1'b1;
                            tcnt      <= 32'h0;
                        end else begin
                            tcnt <= tcnt + 32'h1;
                        end
                    end
                end
                HOLD: begin
                    if (retire && !stall) begin
                        // A target with bit1 set is forced down to the
                        // enclosing word.
                        if (target[1]) begin
                            pc       <= target & ~32'h3;
                            misalign <= 1'b1;
                        end else begin
                            pc <= target;
                        end
                        if (illegal_op) npc_err <= 1'b1;
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        state       <= FETCH;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_unit
//   Directed bench for pc_fetch_unit (IMEM_TIMEOUT=4). Inputs are driven and
//   outputs sampled 1ns after each rising edge.
// ----------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic        stall;
    logic [2:0]  npc_op;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] alu_result;
    logic        misalign;
    logic        npc_err;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    pc_fetch_unit #(.RESET_PC(32'h0), .IMEM_TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .pc(pc), .pc_plus4(pc_plus4),
        .retire(retire), .stall(stall), .npc_op(npc_op),
        .branch_taken(branch_taken), .imm(imm), .alu_result(alu_result),
        .misalign(misalign), .npc_err(npc_err), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Complete a fetch: rdy high until instr_valid, bounded.
    task automatic fetch(input logic [31:0] data);
        int n;
        imem_rdy   = 1'b1;
        imem_rdata = data;
        n = 0;
        do begin
            step();
            n++;
        end while (!instr_valid && n < 20);
        imem_rdy = 1'b0;
        chk("fetch_instr", instr, data);
        chk("fetch_valid", {31'h0, instr_valid}, 32'h1);
    endtask

    // Retire the held instruction and check the new fetch address.
    task automatic do_retire(input string tag, input logic [2:0] op, input logic bt,
                             input logic [31:0] im, input logic [31:0] alu,
                             input logic [31:0] exp_pc);
        npc_op       = op;
        branch_taken = bt;
        imm          = im;
        alu_result   = alu;
        retire       = 1'b1;
        step();
        retire       = 1'b0;
        chk(tag, imem_addr, exp_pc);
        chk({tag, "_req"}, {31'h0, imem_req}, 32'h1);
        chk({tag, "_vld"}, {31'h0, instr_valid}, 32'h0);
    endtask

    initial begin
        rstn = 1'b0; imem_rdy = 1'b0; imem_rdata = 32'h0; retire = 1'b0;
        stall = 1'b0; npc_op = 3'b000; branch_taken = 1'b0; imm = 32'h0;
        alu_result = 32'h0;
        step(); step();
        chk("rst_req",  {31'h0, imem_req}, 32'h0);
        chk("rst_vld",  {31'h0, instr_valid}, 32'h0);
        chk("rst_pc",   pc, 32'h0);
        chk("rst_inst", instr, 32'h0);
        chk("rst_flags", {29'h0, misalign, npc_err, fetch_err}, 32'h0);

        // Start-up: IDLE for one cycle, valid two edges after release.
        rstn = 1'b1; imem_rdy = 1'b1; imem_rdata = 32'h0000_0013;
        step();
        chk("up_req",  {31'h0, imem_req}, 32'h1);
        chk("up_addr", imem_addr, 32'h0);
        chk("up_vld0", {31'h0, instr_valid}, 32'h0);
        step();
        chk("up_vld1", {31'h0, instr_valid}, 32'h1);
        chk("up_inst", instr, 32'h0000_0013);
        imem_rdy = 1'b0;

        do_retire("seq4",  3'b000, 1'b0, 32'h0, 32'h0, 32'h4);   fetch(32'h0000_0013);
        do_retire("seq8",  3'b000, 1'b0, 32'h0, 32'h0, 32'h8);   fetch(32'h0000_0013);
        do_retire("jal100", 3'b010, 1'b0, 32'hF8, 32'h0, 32'h100); fetch(32'h1111_0001);
        do_retire("br_tk", 3'b001, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'hF0); fetch(32'h1111_0002);
        do_retire("jal100b", 3'b010, 1'b0, 32'h10, 32'h0, 32'h100); fetch(32'h1111_0003);
        do_retire("br_nt", 3'b001, 1'b0, 32'hFFFF_FFF0, 32'h0, 32'h104); fetch(32'h1111_0004);
        chk("pc_plus4", pc_plus4, 32'h108);

        do_retire("jal200", 3'b010, 1'b0, 32'hFC, 32'h0, 32'h200); fetch(32'h2222_0001);
        do_retire("jalr_ok", 3'b100, 1'b0, 32'h0, 32'h1001, 32'h1000);
        chk("misalign0", {31'h0, misalign}, 32'h0);
        fetch(32'h2222_0002);
        do_retire("jal200b", 3'b010, 1'b0, 32'hFFFF_F200, 32'h0, 32'h200); fetch(32'h2222_0003);
        do_retire("jalr_mis", 3'b100, 1'b0, 32'h0, 32'h1003, 32'h1000);
        chk("misalign1", {31'h0, misalign}, 32'h1);
        fetch(32'h2222_0004);

        // retire+stall: stall wins for 3 cycles, then exactly one advance.
        npc_op = 3'b000; retire = 1'b1; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc, 32'h1000);
            chk("stall_vld", {31'h0, instr_valid}, 32'h1);
        end
        stall = 1'b0;
        step();
        retire = 1'b0;
        chk("unstall_pc", pc, 32'h1004);
        step();
        chk("one_adv_pc", pc, 32'h1004);
        fetch(32'h3333_0001);

        // Timeout: 4 FETCH cycles without rdy.
        do_retire("to_start", 3'b000, 1'b0, 32'h0, 32'h0, 32'h1008);
        step(); step(); step();
        chk("to_3", {31'h0, fetch_err}, 32'h0);
        step();
        chk("to_4", {31'h0, fetch_err}, 32'h1);
        chk("to_req", {31'h0, imem_req}, 32'h1);
        chk("to_addr", imem_addr, 32'h1008);
        fetch(32'hDEAD_BEEF);
        chk("to_sticky", {31'h0, fetch_err}, 32'h1);

        // Async reset mid-FETCH at pc=0x40.
        do_retire("jal40", 3'b010, 1'b0, 32'hFFFF_F038, 32'h0, 32'h40);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_req", {31'h0, imem_req}, 32'h0);
        chk("ar_pc", pc, 32'h0);
        chk("ar_ferr", {31'h0, fetch_err}, 32'h0);
        imem_rdy = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        step();
        chk("ar_late_rdy", {31'h0, instr_valid}, 32'h0);
        imem_rdy = 1'b0;
        rstn = 1'b1;
        step();
        fetch(32'h4444_0001);
        do_retire("illegal", 3'b011, 1'b0, 32'h0, 32'h0, 32'h4);
        chk("npc_err", {31'h0, npc_err}, 32'h1);
        chk("ill_mis", {31'h0, misalign}, 32'h0);

        // retire outside HOLD is ignored.
        retire = 1'b1;
        step();
        retire = 1'b0;
        chk("ret_fetch", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
